// File: rtl/ds1302_xfer_ctrl.sv
// ds1302_xfer_ctrl: single-byte DS1302 3-wire transfer sequencer.
// Runs CE setup, 8-bit command, 8 data bits (write or read), CE hold and
// CE recovery from a single start strobe. Pin outputs are registered so
// CE/SCLK/IO never glitch; they are computed from the next-state values.
module ds1302_xfer_ctrl #(
  parameter int CLK_DIV  = 50,
  parameter int CE_GUARD = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rd,
  input  logic       ram_sel,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       coe_ce,
  output logic       coe_sclk,
  output logic       coe_io_out,
  output logic       coe_io_oe,
  input  logic       coe_io_in
);

  // One counter serves both the SCLK half-period and the CE guard intervals.
  localparam int CNT_MAX = (CLK_DIV > CE_GUARD) ? CLK_DIV : CE_GUARD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(CE_GUARD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          phase_q, phase_d;   // 0 = SCLK low phase, 1 = SCLK high phase
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rd_q, rd_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ce_q, ce_d;
  logic          sclk_q, sclk_d;
  logic          io_out_q, io_out_d;
  logic          io_oe_q, io_oe_d;

  logic guard_end;
  logic phase_end;

  assign guard_end = (cnt_q == GUARD_LAST);
  assign phase_end = (cnt_q == DIV_LAST);

  // Next-state logic: sequencing, bit counting, read sampling, completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d   = {1'b1, ram_sel, addr, rd};
          wdata_d = wdata;
          rd_d    = rd;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (guard_end) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = 3'd0;
          state_d = S_CMD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_CMD, S_WDATA, S_RDATA: begin
        if (phase_end) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            // Read bits are captured on the last cycle of the low phase.
            if (state_q == S_RDATA) begin
              rx_d[bit_q] = coe_io_in;
            end
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (state_q == S_CMD) begin
                state_d = rd_q ? S_RDATA : S_WDATA;
              end else begin
                state_d = S_HOLD;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HOLD: begin
        if (guard_end) begin
          cnt_d   = '0;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RECOVER: begin
        if (guard_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (rd_q) begin
            rdata_d = rx_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin and status values for the next cycle, decoded from the next state.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    ce_d     = 1'b0;
    sclk_d   = 1'b0;
    io_oe_d  = 1'b0;
    io_out_d = 1'b0;
    case (state_d)
      S_SETUP, S_HOLD: begin
        ce_d = 1'b1;
      end
      S_CMD: begin
        ce_d     = 1'b1;
        sclk_d   = phase_d;
        io_oe_d  = 1'b1;
        io_out_d = cmd_d[bit_d];
      end
      S_WDATA: begin
        ce_d     = 1'b1;
        sclk_d   = phase_d;
        io_oe_d  = 1'b1;
        io_out_d = wdata_d[bit_d];
      end
      S_RDATA: begin
        ce_d   = 1'b1;
        sclk_d = phase_d;
      end
      default: begin
        ce_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      phase_q  <= 1'b0;
      cmd_q    <= 8'd0;
      wdata_q  <= 8'd0;
      rx_q     <= 8'd0;
      rdata_q  <= 8'd0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ce_q     <= 1'b0;
      sclk_q   <= 1'b0;
      io_out_q <= 1'b0;
      io_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ce_q     <= ce_d;
      sclk_q   <= sclk_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign coe_ce     = ce_q;
  assign coe_sclk   = sclk_q;
  assign coe_io_out = io_out_q;
  assign coe_io_oe  = io_oe_q;

endmodule

// File: tb/tb_ds1302_xfer_ctrl.sv
// tb_ds1302_xfer_ctrl: directed and randomized transfers against a
// transaction-level expectation plus a simple DS1302 read-data responder.
module tb_ds1302_xfer_ctrl;

  localparam int D      = 2;
  localparam int G      = 3;
  localparam int BUSY_N = 3 * G + 32 * D;
  localparam int BUDGET = 400;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       rd;
  logic       ram_sel;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       coe_ce;
  logic       coe_sclk;
  logic       coe_io_out;
  logic       coe_io_oe;
  logic       coe_io_in;

  int         vectors;
  int         miscompares;
  logic [7:0] exp_rdata;
  logic [7:0] rtc_byte;
  int         rises;
  int         viol;
  logic       mon_sclk;
  logic       mon_io;

  ds1302_xfer_ctrl #(.CLK_DIV(D), .CE_GUARD(G)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .rd         (rd),
    .ram_sel    (ram_sel),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .coe_ce     (coe_ce),
    .coe_sclk   (coe_sclk),
    .coe_io_out (coe_io_out),
    .coe_io_oe  (coe_io_oe),
    .coe_io_in  (coe_io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DS1302 responder: after the 8 command clocks it presents data bit n
  // during the n-th following SCLK low phase.
  assign coe_io_in = (rises >= 8 && rises < 16) ? rtc_byte[rises[2:0]] : 1'b0;

  // Pin-rule monitor and SCLK rise counter for the responder.
  always @(negedge clk) begin
    mon_sclk <= coe_sclk;
    mon_io   <= coe_io_out;
    if (!coe_ce) rises <= 0;
    else if (coe_sclk && !mon_sclk) rises <= rises + 1;
    viol <= viol + ((coe_sclk && !coe_ce) ? 1 : 0)
                 + ((coe_io_oe && !coe_ce) ? 1 : 0)
                 + ((coe_sclk && (coe_io_out !== mon_io)) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Runs one transfer starting in the current (idle or done) cycle.
  task automatic run_xfer(input bit t_rd, input bit t_rs, input logic [4:0] t_addr,
                          input logic [7:0] t_wd, input logic [7:0] t_rtc,
                          input bit glitch, input bit settle);
    logic [7:0]  cmd;
    logic [15:0] io_at_rise;
    logic [15:0] oe_at_rise;
    int c, nrise, cerise, firstrise, lastfall, cefall, oedrop, dones_busy;
    bit p_sclk, p_ce, p_oe, finished;
    cmd        = 8'h80 | (8'(t_rs) << 6) | (8'(t_addr) << 1) | 8'(t_rd);
    rtc_byte   = t_rtc;
    io_at_rise = '0;
    oe_at_rise = '0;
    nrise = 0; cerise = -1; firstrise = -1; lastfall = -1; cefall = -1;
    oedrop = -1; dones_busy = 0;
    p_sclk = 1'b0; p_ce = 1'b0; p_oe = 1'b0; finished = 1'b0;
    start = 1'b1; rd = t_rd; ram_sel = t_rs; addr = t_addr; wdata = t_wd;
    c = 0;
    while (!finished && c < BUDGET) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (c == 10) begin
        rd = 1'($urandom); ram_sel = 1'($urandom);
        addr = 5'($urandom); wdata = 8'($urandom);
      end
      if (glitch && c == 20) begin
        start = 1'b1; addr = ~t_addr; rd = ~t_rd; wdata = ~t_wd;
      end
      if (!busy) begin
        finished = 1'b1;
      end else begin
        if (done) dones_busy++;
        if (coe_ce && !p_ce && cerise < 0) cerise = c;
        if (!coe_ce && p_ce) cefall = c;
        if (coe_sclk && !p_sclk) begin
          if (nrise < 16) begin
            io_at_rise[nrise] = coe_io_out;
            oe_at_rise[nrise] = coe_io_oe;
          end
          if (nrise == 0) firstrise = c;
          nrise++;
        end
        if (!coe_sclk && p_sclk) lastfall = c;
        if (!coe_io_oe && p_oe && oedrop < 0) oedrop = c;
        p_sclk = coe_sclk; p_ce = coe_ce; p_oe = coe_io_oe;
      end
    end
    start = 1'b0;
    if (!finished) begin
      chk("busy_timeout", 32'(c), 32'(BUSY_N + 1));
      return;
    end
    if (t_rd) exp_rdata = t_rtc;
    chk("busy_len", 32'(c - 1), 32'(BUSY_N));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_during_busy", 32'(dones_busy), 32'd0);
    chk("rdata_at_done", 32'(rdata), 32'(exp_rdata));
    chk("sclk_rises", 32'(nrise), 32'd16);
    chk("cmd_bits", 32'(io_at_rise[7:0]), 32'(cmd));
    if (!t_rd) chk("wdata_bits", 32'(io_at_rise[15:8]), 32'(t_wd));
    chk("oe_cmd", 32'(oe_at_rise[7:0]), 32'hFF);
    chk("oe_data", 32'(oe_at_rise[15:8]), t_rd ? 32'h00 : 32'hFF);
    chk("ce_rise", 32'(cerise), 32'd1);
    chk("ce_to_first_rise", 32'(firstrise - cerise), 32'(G + D));
    chk("ce_hold", 32'(cefall - lastfall), 32'(G));
    chk("ce_recover", 32'(c - cefall), 32'(G));
    chk("oe_drop", 32'(oedrop), t_rd ? 32'(G + 16 * D + 1) : 32'(G + 32 * D + 1));
    chk("pin_rules", 32'(viol), 32'd0);
    if (settle) begin
      @(negedge clk);
      chk("done_width", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("rdata_hold", 32'(rdata), 32'(exp_rdata));
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_rdata = 8'h00; rtc_byte = 8'h00;
    rises = 0; viol = 0; mon_sclk = 1'b0; mon_io = 1'b0;
    reset_n = 1'b0; start = 1'b0; rd = 1'b0; ram_sel = 1'b0; addr = 5'd0; wdata = 8'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy, done, rdata, coe_ce, coe_sclk, coe_io_out, coe_io_oe}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'({busy, done, rdata, coe_ce, coe_sclk, coe_io_out, coe_io_oe}), 32'd0);

    // Directed write and read from the plan.
    run_xfer(1'b0, 1'b0, 5'h00, 8'h5A, 8'($urandom), 1'b0, 1'b1);
    run_xfer(1'b1, 1'b1, 5'h1F, 8'($urandom), 8'hA5, 1'b0, 1'b1);

    // Start pulse while busy must be ignored.
    run_xfer(1'b0, 1'b1, 5'h0A, 8'h3C, 8'h00, 1'b1, 1'b1);
    run_xfer(1'b1, 1'b0, 5'h15, 8'h00, 8'h69, 1'b1, 1'b1);

    // Back-to-back: second start lands in the done cycle of the first.
    run_xfer(1'b1, 1'b0, 5'h05, 8'h11, 8'h96, 1'b0, 1'b0);
    run_xfer(1'b0, 1'b0, 5'h12, 8'hC3, 8'h00, 1'b0, 1'b1);

    // Randomized transfers.
    for (int i = 0; i < 6; i++) begin
      run_xfer(1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset during RDATA bit 3: outputs clear asynchronously, no done pulse.
    begin
      int c;
      rtc_byte = 8'($urandom);
      start = 1'b1; rd = 1'b1; ram_sel = 1'b0; addr = 5'h07; wdata = 8'h00;
      for (c = 1; c <= G + 16 * D + 3 * 2 * D + 2; c++) begin
        @(negedge clk);
        start = 1'b0;
      end
      chk("pre_reset_rdata_phase", 32'({busy, coe_ce, coe_io_oe}), 32'b110);
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({busy, done, rdata, coe_ce, coe_sclk, coe_io_out, coe_io_oe}), 32'd0);
      exp_rdata = 8'h00;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("no_done_in_reset", 32'({done, busy}), 32'd0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      chk("no_done_after_abort", 32'({done, busy}), 32'd0);
    end
    run_xfer(1'b0, 1'b1, 5'h03, 8'($urandom), 8'h00, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
